// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds the word for decode via valid/ready.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned branch target traps (S_TRAP) instead of being aligned.
module instr_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instret,
   output logic            fetch_fault
);

   // Handshakes: imem_req/imem_addr stay stable until imem_ack (ack may come in the req cycle);
   // instr/pc stay stable while instr_valid && !instr_ready; a transfer happens when both are high.
`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_RST = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2, S_TRAP = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_RST = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2} state_t;
`endif

   state_t          state, next_state;
   logic            accept;
   logic            misalign;
   logic [XLEN-1:0] target_aligned;

   assign accept         = (state == S_HOLD) && instr_valid && instr_ready;
   assign misalign       = branch_taken && (branch_target[1:0] != 2'b00);
   assign target_aligned = branch_target & ~XLEN'(3);
   assign imem_req       = (state == S_FETCH);
   assign imem_addr      = pc;

   always_comb begin
      next_state = state;
      case (state)
         S_RST:   next_state = S_FETCH;
         S_FETCH: if (imem_ack) next_state = S_HOLD;
         S_HOLD: begin
            if (accept) begin
`ifdef FETCH_MISALIGN_TRAP_EN
               next_state = misalign ? S_TRAP : S_FETCH;
`else
               next_state = S_FETCH;
`endif
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         S_TRAP:  next_state = S_TRAP;
`endif
         default: next_state = S_RST;
      endcase
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_RST;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         instret     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         state <= next_state;
         if ((state == S_FETCH) && imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
         end
         if (accept) begin
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            if (branch_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (misalign) begin
                  pc      <= branch_target;
                  fault_q <= 1'b1;
               end else begin
                  pc <= target_aligned;
               end
`else
               pc <= target_aligned;
`endif
            end else begin
               pc <= pc + XLEN'(PC_STEP);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: reset, sequential fetch, stalls, branch, wrap, misaligned target.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic [31:0] instret;
   logic        fetch_fault;

   int n_checks = 0;
   int n_pass   = 0;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .instret(instret), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects to be in S_FETCH at exp_addr; ack in the request cycle.
   task automatic do_fetch(input logic [31:0] data, input logic [31:0] exp_addr);
      check("fetch_req", {31'b0, imem_req}, 32'd1);
      check("fetch_addr", imem_addr, exp_addr);
      imem_ack = 1'b1; imem_rdata = data;
      tick();
      imem_ack = 1'b0;
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_instr", instr, data);
      check("hold_pc", pc, exp_addr);
      check("hold_req", {31'b0, imem_req}, 32'd0);
   endtask

   task automatic do_accept(input logic br, input logic [31:0] tgt, input logic [31:0] exp_ret);
      instr_ready = 1'b1; branch_taken = br; branch_target = tgt;
      tick();
      instr_ready = 1'b0; branch_taken = 1'b0;
      check("acc_valid", {31'b0, instr_valid}, 32'd0);
      check("acc_instret", instret, exp_ret);
   endtask

   initial begin
      reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_instr", instr, 32'h0);
         check("rst_valid", {31'b0, instr_valid}, 32'd0);
         check("rst_req", {31'b0, imem_req}, 32'd0);
         check("rst_instret", instret, 32'd0);
         check("rst_fault", {31'b0, fetch_fault}, 32'd0);
      end
      reset = 1'b1;
      tick();

      // Sequential fetch
      do_fetch(32'h002080B3, 32'h0);
      do_accept(1'b0, 32'h0, 32'd1);
      do_fetch(32'h40208133, 32'h4);
      do_accept(1'b0, 32'h0, 32'd2);
      do_fetch(32'h00310233, 32'h8);

      // Backpressure: 4 cycles without ready
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_instr", instr, 32'h00310233);
         check("bp_pc", pc, 32'h8);
         check("bp_req", {31'b0, imem_req}, 32'd0);
         check("bp_valid", {31'b0, instr_valid}, 32'd1);
      end

      // Branch accepted at pc=8
      do_accept(1'b1, 32'h40, 32'd3);

      // Slow memory; branch_taken during fetch must be ignored
      branch_taken = 1'b1; branch_target = 32'h100;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("slow_req", {31'b0, imem_req}, 32'd1);
         check("slow_addr", imem_addr, 32'h40);
      end
      branch_taken = 1'b0;
      do_fetch(32'h00000013, 32'h40);

      // PC wrap at top of address space
      do_accept(1'b1, 32'hFFFF_FFFC, 32'd4);
      do_fetch(32'h00100093, 32'hFFFF_FFFC);
      do_accept(1'b0, 32'h0, 32'd5);
      do_fetch(32'h00200113, 32'h0);
      do_accept(1'b0, 32'h0, 32'd6);

      // Reset while waiting for ack at pc=4; the late ack is discarded
      check("pre_rst_addr", imem_addr, 32'h4);
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
      check("mid_rst_instr", instr, 32'h0);
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_instret", instret, 32'd0);
      check("mid_rst_req", {31'b0, imem_req}, 32'd0);
      reset = 1'b1;
      tick();
      imem_ack = 1'b0;
      check("post_rst_valid", {31'b0, instr_valid}, 32'd0);
      check("post_rst_instr", instr, 32'h0);

      // Misaligned branch target
      do_fetch(32'h00300193, 32'h0);
      do_accept(1'b1, 32'h42, 32'd1);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("trap_fault", {31'b0, fetch_fault}, 32'd1);
      check("trap_pc", pc, 32'h42);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("trap_req", {31'b0, imem_req}, 32'd0);
         check("trap_valid", {31'b0, instr_valid}, 32'd0);
      end
      reset = 1'b0;
      tick();
      check("trap_rst_fault", {31'b0, fetch_fault}, 32'd0);
      reset = 1'b1;
      tick();
      check("trap_rst_addr", imem_addr, 32'h0);
`else
      check("mis_fault", {31'b0, fetch_fault}, 32'd0);
      do_fetch(32'h00400213, 32'h40);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
